// File: rtl/key_event_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_event_gen_pkg
// Description : Shared key indices and repeat-FSM encoding for the key front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package key_event_gen_pkg;

    localparam int KEY_LEFT    = 0;
    localparam int KEY_RIGHT   = 1;
    localparam int KEY_UP      = 2;
    localparam int KEY_DOWN    = 3;
    localparam int KEY_CONFIRM = 4;
    localparam int KEY_QUIT    = 5;

    typedef enum logic [1:0] {
        RPT_IDLE = 2'd0,
        RPT_HOLD = 2'd1,
        RPT_RPT  = 2'd2
    } rpt_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_ch.sv
`default_nettype none
// ============================================================================
// Module      : key_event_ch
// Description : One key line: 2-flop sync, debounce, press/release edges and
//               auto-repeat FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_ch
    import key_event_gen_pkg::*;
#(
    parameter int DELAY         = 1000,
    parameter int ACTIVE_LOW    = 1,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic key_level,
    output logic press,
    output logic key_release,
    output logic key_repeat
);

    localparam int   c_cnt_w  = $clog2(DELAY);
    localparam int   c_hcnt_w = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic c_idle_pin = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(DELAY - 1);
    localparam logic [c_hcnt_w-1:0] c_hold_last = c_hcnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_hcnt_w-1:0] c_rpt_last  = c_hcnt_w'(REPEAT_CYCLES - 1);

    logic                r_sync1;
    logic                r_sync2;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_level;
    logic                r_press;
    logic                r_release;
    logic                r_repeat;
    rpt_state_t          r_state;
    logic [c_hcnt_w-1:0] r_hcnt;

    logic w_pressed;
    logic w_toggle;
    logic w_rise;
    logic w_fall;

    assign w_pressed = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
    assign w_toggle  = (w_pressed != r_level) && (r_cnt == c_cnt_last);
    assign w_rise    = w_toggle &  w_pressed;
    assign w_fall    = w_toggle & ~w_pressed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= c_idle_pin;
            r_sync2   <= c_idle_pin;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            r_state   <= RPT_IDLE;
            r_hcnt    <= '0;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;

            // Any cycle agreeing with the accepted level restarts the stability window.
            if (w_pressed == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_cnt   <= '0;
                r_level <= w_pressed;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end

            r_press   <= w_rise;
            r_release <= w_fall;
            r_repeat  <= 1'b0;

            // Release wins over a repeat falling due in the same cycle.
            if (w_fall || !REPEAT_EN) begin
                r_state <= RPT_IDLE;
                r_hcnt  <= '0;
            end else begin
                case (r_state)
                    RPT_IDLE: begin
                        if (w_rise) begin
                            r_state <= RPT_HOLD;
                            r_hcnt  <= '0;
                        end
                    end
                    RPT_HOLD: begin
                        if (r_hcnt == c_hold_last) begin
                            r_repeat <= 1'b1;
                            r_hcnt   <= '0;
                            r_state  <= RPT_RPT;
                        end else begin
                            r_hcnt <= r_hcnt + c_hcnt_w'(1);
                        end
                    end
                    RPT_RPT: begin
                        if (r_hcnt == c_rpt_last) begin
                            r_repeat <= 1'b1;
                            r_hcnt   <= '0;
                        end else begin
                            r_hcnt <= r_hcnt + c_hcnt_w'(1);
                        end
                    end
                    default: begin
                        r_state <= RPT_IDLE;
                        r_hcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign key_level   = r_level;
    assign press       = r_press;
    assign key_release = r_release;
    assign key_repeat  = r_repeat;

endmodule
`default_nettype wire

// File: rtl/key_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : key_event_gen
// Description : Panel-key front-end: per-key debounce/edge/repeat channels
//               plus a combined event flag.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_gen
    import key_event_gen_pkg::*;
#(
    parameter int                N_KEYS        = 8,
    parameter int                DELAY         = 1000,
    parameter int                ACTIVE_LOW    = 1,
    parameter int                HOLD_CYCLES   = 25000000,
    parameter int                REPEAT_CYCLES = 5000000,
    parameter logic [N_KEYS-1:0] REPEAT_MASK   = 8'h0F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat,
    output logic              any_event
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_event_ch #(
            .DELAY         (DELAY),
            .ACTIVE_LOW    (ACTIVE_LOW),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .REPEAT_EN     (REPEAT_MASK[i])
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .key_in      (key_in[i]),
            .key_level   (key_level[i]),
            .press       (press[i]),
            .key_release (key_release[i]),
            .key_repeat  (key_repeat[i])
        );
    end

    assign any_event = |(press | key_release | key_repeat);

endmodule
`default_nettype wire

// File: tb/tb_key_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_gen
// Description : Directed scoreboard bench for key_event_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] key_in;
    logic [7:0] key_level;
    logic [7:0] press;
    logic [7:0] key_release;
    logic [7:0] key_repeat;
    logic       any_event;

    typedef struct {
        int         cyc;
        logic [7:0] p;
        logic [7:0] r;
        logic [7:0] t;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;
    int  cyc    = 0;
    int  errors = 0;
    int  checks = 0;

    key_event_gen #(
        .N_KEYS        (8),
        .DELAY         (4),
        .ACTIVE_LOW    (1),
        .HOLD_CYCLES   (10),
        .REPEAT_CYCLES (3),
        .REPEAT_MASK   (8'h0F)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_in      (key_in),
        .key_level   (key_level),
        .press       (press),
        .key_release (key_release),
        .key_repeat  (key_repeat),
        .any_event   (any_event)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input logic [7:0] p, input logic [7:0] r, input logic [7:0] t);
        ev_t e;
        e.cyc = c; e.p = p; e.r = r; e.t = t;
        q.push_back(e);
    endtask

    // Scoreboard: every cycle either matches the queued event or must be quiet.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
            mon_e = q.pop_front();
            chk("press", press, mon_e.p);
            chk("release", key_release, mon_e.r);
            chk("repeat", key_repeat, mon_e.t);
            chk("any_event_hi", {7'd0, any_event}, 8'h01);
        end else begin
            chk("quiet_pulses", press | key_release | key_repeat, 8'h00);
            chk("quiet_any", {7'd0, any_event}, 8'h00);
        end
    end

    initial begin
        reset  = 1'b1;
        key_in = 8'h00;
        wait_cyc(2);
        chk("rst_level", key_level, 8'h00);
        chk("rst_press", press, 8'h00);
        chk("rst_release", key_release, 8'h00);
        chk("rst_repeat", key_repeat, 8'h00);
        chk("rst_any", {7'd0, any_event}, 8'h00);

        // All keys held through reset: fresh press 6 edges after release of reset
        reset = 1'b0;
        push(8, 8'hFF, 8'h00, 8'h00);
        wait_cyc(8);
        chk("level_all", key_level, 8'hFF);
        key_in = 8'hFF;
        push(14, 8'h00, 8'hFF, 8'h00);
        wait_cyc(14);
        chk("level_none", key_level, 8'h00);

        // Bounce on key 4
        wait_cyc(20);
        key_in[4] = 1'b0;
        wait_cyc(23);
        key_in[4] = 1'b1;
        wait_cyc(24);
        key_in[4] = 1'b0;
        push(30, 8'h10, 8'h00, 8'h00);
        wait_cyc(29);
        chk("bounce_early", key_level, 8'h00);
        wait_cyc(30);
        chk("bounce_level", key_level, 8'h10);
        key_in[4] = 1'b1;
        push(36, 8'h00, 8'h10, 8'h00);
        wait_cyc(36);

        // Glitch on key 0 shorter than the debounce window
        wait_cyc(40);
        key_in[0] = 1'b0;
        wait_cyc(43);
        key_in[0] = 1'b1;
        wait_cyc(55);
        chk("glitch_level", key_level, 8'h00);

        // Auto-repeat on key 2
        wait_cyc(60);
        key_in[2] = 1'b0;
        push(66, 8'h04, 8'h00, 8'h00);
        for (int j = 16; j <= 34; j += 3) push(60 + j, 8'h00, 8'h00, 8'h04);
        wait_cyc(90);
        key_in[2] = 1'b1;
        push(96, 8'h00, 8'h04, 8'h00);
        wait_cyc(96);
        chk("rpt_level", key_level, 8'h00);

        // Masked key 5 never repeats
        wait_cyc(110);
        key_in[5] = 1'b0;
        push(116, 8'h20, 8'h00, 8'h00);
        wait_cyc(140);
        chk("masked_level", key_level, 8'h20);
        key_in[5] = 1'b1;
        push(146, 8'h00, 8'h20, 8'h00);

        // Simultaneous keys 0/1, reset while held
        wait_cyc(150);
        key_in = 8'hFC;
        push(156, 8'h03, 8'h00, 8'h00);
        wait_cyc(156);
        chk("simul_level", key_level, 8'h03);
        wait_cyc(158);
        reset = 1'b1;
        wait_cyc(160);
        chk("midrst_level", key_level, 8'h00);
        reset = 1'b0;
        push(166, 8'h03, 8'h00, 8'h00);
        wait_cyc(166);
        chk("repress_level", key_level, 8'h03);
        wait_cyc(170);
        key_in = 8'hFF;
        // Release lands exactly when the first repeat would have fired
        push(176, 8'h00, 8'h03, 8'h00);
        wait_cyc(176);
        chk("final_level", key_level, 8'h00);
        wait_cyc(190);

        for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
        chk("drain_pending", 8'(q.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
